// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide unit.
//   t_md_op     - M-extension func3 encodings
//   t_md_state  - control FSM states
//   MD_*        - special-case result constants (sliced to XLEN by users)
//   md_sext_w   - sign-extend a 32-bit W-op result to 64 bits
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } t_md_op;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    CALC,
    DONE
  } t_md_state;

  localparam logic [63:0] MD_DIVZ_QUOT   = '1;
  localparam logic [63:0] MD_ILLEGAL_RES = '0;
  localparam logic [63:0] MD_OVF_REM     = '0;
  localparam logic [31:0] MD_MIN_W       = 32'h8000_0000;

  function automatic logic [63:0] md_sext_w(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the iterative datapath.
//   is_div   - 1: restoring divide step, 0: shift-add multiply step
//   acc      - multiply: 2N-bit partial product; divide: {remainder, quotient}
//   opnd     - multiplicand (multiply) or divisor (divide)
//   src_bit  - current multiplier / dividend bit, MSB first
//   acc_next - accumulator after this iteration
module muldiv_step #(
  parameter int N = 64
) (
  input  logic           is_div,
  input  logic [2*N-1:0] acc,
  input  logic [N-1:0]   opnd,
  input  logic           src_bit,
  output logic [2*N-1:0] acc_next
);

  logic [N:0] trial;
  logic [N:0] diff;

  always_comb begin
    trial = {acc[2*N-1:N], src_bit};
    diff  = trial - {1'b0, opnd};
    if (is_div) begin
      // Remainder stays below the divisor, so bit N of diff is a clean borrow flag.
      if (!diff[N]) acc_next = {diff[N-1:0], acc[N-2:0], 1'b1};
      else          acc_next = {trial[N-1:0], acc[N-2:0], 1'b0};
    end else begin
      acc_next = {acc[2*N-2:0], 1'b0} + (src_bit ? {{N{1'b0}}, opnd} : '0);
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide unit (XLEN 32 or 64).
//   i_clk, i_arstn        - clock, asynchronous active-low reset
//   i_valid / o_ready     - request handshake (o_ready only in IDLE)
//   i_func3, i_word       - M op code and W-variant flag
//   i_op_a, i_op_b        - rs1 / rs2
//   i_flush               - abort any in-flight op, result discarded
//   o_valid / i_ready     - result handshake (o_valid only in DONE)
//   o_result              - result, stable while in DONE
//   o_busy                - any state other than IDLE
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int WORD_EN = 1
) (
  input  logic            i_clk,
  input  logic            i_arstn,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_func3,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam bit              WEN   = (XLEN == 64) && (WORD_EN != 0);
  localparam int              CW    = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] WMASK = XLEN'(64'h0000_0000_FFFF_FFFF);

  t_md_state         state, state_next;
  t_md_op            op_q;
  logic              word_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q, src_q;
  logic [CW-1:0]     cnt_q;
  logic              sign_q;

  // Operand preparation, evaluated from the latched request during PREP.
  logic              is_div, signed_a, signed_b, neg_a, neg_b, rec_sign;
  logic              div_zero, ovf, illegal, special;
  logic [XLEN-1:0]   nmask, a_n, b_n, mag_a, mag_b, a_ret, spec_res;
  logic [63:0]       sx_a;

  always_comb begin
    is_div   = op_q[2];
    signed_a = op_q inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    signed_b = op_q inside {MD_MULH, MD_DIV, MD_REM};
    nmask    = word_q ? WMASK : '1;
    a_n      = a_q & nmask;
    b_n      = b_q & nmask;
    neg_a    = signed_a & (word_q ? a_q[31] : a_q[XLEN-1]);
    neg_b    = signed_b & (word_q ? b_q[31] : b_q[XLEN-1]);
    mag_a    = neg_a ? ((-a_n) & nmask) : a_n;
    mag_b    = neg_b ? ((-b_n) & nmask) : b_n;
    // Remainder takes the dividend's sign; products and quotients the xor.
    rec_sign = (is_div && op_q[1]) ? neg_a : (neg_a ^ neg_b);
    sx_a     = md_sext_w(a_q[31:0]);
    a_ret    = word_q ? sx_a[XLEN-1:0] : a_q;
    div_zero = is_div && (b_n == '0);
    ovf      = is_div && !op_q[0] &&
               (word_q ? (a_q[31:0] == MD_MIN_W && b_q[31:0] == 32'hFFFF_FFFF)
                       : (a_q == MIN_X && b_q == '1));
    illegal  = word_q && (op_q inside {MD_MULH, MD_MULHSU, MD_MULHU});
    special  = illegal || div_zero || ovf;
    if (illegal)       spec_res = MD_ILLEGAL_RES[XLEN-1:0];
    else if (div_zero) spec_res = op_q[1] ? a_ret : MD_DIVZ_QUOT[XLEN-1:0];
    else               spec_res = op_q[1] ? MD_OVF_REM[XLEN-1:0] : a_ret;
  end

  logic [2*XLEN-1:0] step_acc, prod_fix;
  logic [XLEN-1:0]   div_raw, div_fix, raw_res, calc_res;
  logic [63:0]       sx_res;

  muldiv_step #(.N(XLEN)) u_step (
    .is_div   (op_q[2]),
    .acc      (acc_q),
    .opnd     (opnd_q),
    .src_bit  (src_q[cnt_q]),
    .acc_next (step_acc)
  );

  // Final-iteration result: sign fix on the full product (so MULH* sees the
  // borrow from the low half), separately on quotient/remainder for divides.
  always_comb begin
    prod_fix = sign_q ? -step_acc : step_acc;
    div_raw  = op_q[1] ? step_acc[2*XLEN-1:XLEN] : step_acc[XLEN-1:0];
    div_fix  = sign_q ? -div_raw : div_raw;
    if (op_q[2])              raw_res = div_fix;
    else if (op_q == MD_MUL)  raw_res = prod_fix[XLEN-1:0];
    else                      raw_res = prod_fix[2*XLEN-1:XLEN];
    sx_res   = md_sext_w(raw_res[31:0]);
    calc_res = word_q ? sx_res[XLEN-1:0] : raw_res;
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (i_valid) state_next = PREP;
      PREP: state_next = special ? DONE : CALC;
      CALC: if (cnt_q == '0) state_next = DONE;
      DONE: if (i_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (i_flush) state_next = IDLE;
    o_ready = (state == IDLE);
    o_valid = (state == DONE);
    o_busy  = (state != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      op_q     <= MD_MUL;
      word_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      src_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      o_result <= '0;
    end else if (!i_flush) begin
      unique case (state)
        IDLE: if (i_valid) begin
          op_q   <= t_md_op'(i_func3);
          word_q <= i_word & WEN;
          a_q    <= i_op_a;
          b_q    <= i_op_b;
        end
        PREP: begin
          sign_q <= rec_sign;
          acc_q  <= '0;
          cnt_q  <= word_q ? CW'(31) : CW'(XLEN - 1);
          opnd_q <= is_div ? mag_b : mag_a;
          src_q  <= is_div ? mag_a : mag_b;
          if (special) o_result <= spec_res;
        end
        CALC: begin
          acc_q <= step_acc;
          if (cnt_q == '0) o_result <= calc_res;
          else             cnt_q    <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        rdy;
  logic [2:0]  func3 = '0;
  logic        word = 1'b0;
  logic [63:0] op_a = '0, op_b = '0;
  logic        flush = 1'b0;
  logic        vld;
  logic        cons_ready = 1'b0;
  logic [63:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [63:0] res;
    int          lat;
  } t_exp;
  t_exp sb[$];

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(64), .WORD_EN(1)) dut (
    .i_clk    (clk),
    .i_arstn  (arstn),
    .i_valid  (in_valid),
    .o_ready  (rdy),
    .i_func3  (func3),
    .i_word   (word),
    .i_op_a   (op_a),
    .i_op_b   (op_b),
    .i_flush  (flush),
    .o_valid  (vld),
    .i_ready  (cons_ready),
    .o_result (result),
    .o_busy   (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V M semantics written directly with wide arithmetic.
  function automatic logic [63:0] model(input logic [2:0] f, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       ax, bx, p;
    logic [31:0]        r32;
    logic signed [31:0] sq32;
    logic signed [63:0] sq;
    if (w) begin
      if (f inside {3'd1, 3'd2, 3'd3}) return '0;
      if (f == 3'd0) r32 = a[31:0] * b[31:0];
      else if (b[31:0] == '0) r32 = f[1] ? a[31:0] : '1;
      else if (!f[0] && a[31:0] == 32'h8000_0000 && b[31:0] == '1) r32 = f[1] ? '0 : a[31:0];
      else if (f[0]) r32 = f[1] ? (a[31:0] % b[31:0]) : (a[31:0] / b[31:0]);
      else begin
        sq32 = f[1] ? ($signed(a[31:0]) % $signed(b[31:0])) : ($signed(a[31:0]) / $signed(b[31:0]));
        r32 = sq32;
      end
      return {{32{r32[31]}}, r32};
    end
    if (!f[2]) begin
      ax = (f == 3'd1 || f == 3'd2) ? {{64{a[63]}}, a} : {64'b0, a};
      bx = (f == 3'd1) ? {{64{b[63]}}, b} : {64'b0, b};
      p  = ax * bx;
      return (f == 3'd0) ? p[63:0] : p[127:64];
    end
    if (b == '0) return f[1] ? a : '1;
    if (!f[0] && a == 64'h8000_0000_0000_0000 && b == '1) return f[1] ? '0 : a;
    if (f[0]) return f[1] ? (a % b) : (a / b);
    sq = f[1] ? ($signed(a) % $signed(b)) : ($signed(a) / $signed(b));
    return sq;
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
    if (w && f inside {3'd1, 3'd2, 3'd3}) return 2;
    if (f[2] && (w ? b[31:0] == '0 : b == '0)) return 2;
    if (f[2] && !f[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                            : (a == 64'h8000_0000_0000_0000 && b == '1))) return 2;
    return w ? 34 : 66;
  endfunction

  // Issue one op, then collect it from the scoreboard when o_valid appears.
  // cyc counts cycles from the accept cycle (0) to the first o_valid cycle.
  task automatic do_op(input string tag, input logic [2:0] f, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_res, input int exp_lat, input int hold);
    int   cyc;
    t_exp e;
    @(negedge clk);
    in_valid = 1'b1; func3 = f; word = w; op_a = a; op_b = b;
    sb.push_back('{tag, exp_res, exp_lat});
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    chk({tag, "_rdy_busy"}, {63'b0, rdy}, 64'd0);
    while (!vld && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    e = sb.pop_front();
    chk({e.tag, "_valid"}, {63'b0, vld}, 64'd1);
    chk({e.tag, "_res"}, result, e.res);
    chk({e.tag, "_lat"}, 64'(cyc), 64'(e.lat));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({e.tag, "_hold_valid"}, {63'b0, vld}, 64'd1);
      chk({e.tag, "_hold_res"}, result, e.res);
    end
    cons_ready = 1'b1;
    @(negedge clk);
    cons_ready = 1'b0;
    chk({e.tag, "_drop"}, {62'b0, vld, rdy}, 64'd1);
  endtask

  task automatic watch_no_valid(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (vld) seen++;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rf;
    logic        rw;
    logic [63:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("rst_outs", {60'b0, rdy, vld, busy, 1'b0}, 64'b1000);
    chk("rst_result", result, 64'd0);
    arstn = 1'b1;
    @(negedge clk);

    do_op("mul", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, 0);
    do_op("mulhu", 3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
    do_op("mulh", 3'd1, 1'b0, '1, '1, 64'd0, 66, 0);
    do_op("mulhsu", 3'd2, 1'b0, '1, 64'd2, '1, 66, 0);
    do_op("divu0", 3'd5, 1'b0, 64'd100, 64'd0, '1, 2, 0);
    do_op("remu0", 3'd7, 1'b0, 64'd100, 64'd0, 64'd100, 2, 0);
    do_op("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 2, 0);
    do_op("rem_ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 2, 0);
    do_op("divw", 3'd4, 1'b1, 64'h0000_0001_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 34, 0);
    do_op("rem_neg", 3'd6, 1'b0, -64'sd7, 64'd2, '1, 66, 0);
    do_op("mulw", 3'd0, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 34, 0);
    do_op("remw0", 3'd6, 1'b1, 64'hABCD_0000_8000_0005, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0005, 2, 0);
    do_op("mulhw_ill", 3'd1, 1'b1, '1, '1, 64'd0, 2, 0);
    do_op("divw_ovf", 3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2, 0);
    do_op("bp_mul", 3'd0, 1'b0, 64'd3, 64'd5, 64'd15, 66, 5);

    for (int i = 0; i < 24; i++) begin
      rf = 3'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rb = 64'($urandom_range(0, 9)) - 64'd4;
      if ($urandom_range(0, 3) == 0) ra = 64'($urandom_range(0, 200)) - 64'd100;
      do_op("rnd", rf, rw, ra, rb, model(rf, rw, ra, rb), model_lat(rf, rw, ra, rb), 0);
    end

    // Flush in CALC cycle 10: accept cycle is 0, PREP is 1, CALC starts at 2.
    @(negedge clk);
    in_valid = 1'b1; func3 = 3'd0; word = 1'b0; op_a = 64'd9; op_b = 64'd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_state", {61'b0, rdy, vld, busy}, 64'b100);
    watch_no_valid("flush_no_valid", 80);

    // Flush alongside a request in IDLE must not accept it.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", {63'b0, busy}, 64'd0);
    watch_no_valid("flush_idle_no_valid", 80);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    in_valid = 1'b1; func3 = 3'd4; word = 1'b0; op_a = 64'd1000; op_b = 64'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    arstn = 1'b0;
    #1;
    chk("arst_outs", {61'b0, rdy, vld, busy}, 64'b100);
    chk("arst_result", result, 64'd0);
    @(negedge clk);
    arstn = 1'b1;
    watch_no_valid("arst_no_valid", 80);

    do_op("post_rst_divu", 3'd5, 1'b0, 64'd1000, 64'd7, 64'd142, 66, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
